// File: rtl/mem_cmd_issuer.sv
// Command FIFO plus replay FSM driving a level-sensitive memory datapath strobe interface.
// Optional issue statistics are built when MEM_CMD_ISSUER_STATS_EN is defined.
module mem_cmd_issuer #(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int WR_HOLD    = 2,
  parameter int RD_LATENCY = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WIDTH-1:0]  cmd_data,
  output logic              enable,
  output logic              write_enable,
  output logic              read_enable,
  output logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  data_in,
  input  logic [WIDTH-1:0]  rd_data_in,
  input  logic              err_in,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              halted,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  // state | meaning
  // IDLE  | waiting for a queued command
  // ISSUE | strobe held, address/data stable
  // RSP   | waiting out read latency, capture at exit
  // GAP   | spacing after a write
  // HALT  | datapath error seen, left only by rst
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RSP, S_GAP, S_HALT} state_t;

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int HOLD_A   = (WR_HOLD > RD_LATENCY) ? WR_HOLD : RD_LATENCY;
  localparam int HOLD_MAX = (HOLD_A > GAP_CYCLES) ? HOLD_A : GAP_CYCLES;
  localparam int CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } cmd_t;

  cmd_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             full, empty, push, pop;
  cmd_t             head;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic              we_q, we_d, re_q, re_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              rsp_v_q, rsp_v_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;

  assign full      = (fifo_cnt == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty     = (fifo_cnt == '0);
  assign halted    = (state_q == S_HALT);
  assign cmd_ready = !rst && !full && !halted;
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Hold counters load N-1 on entry and leave the state at terminal count zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_wr_d    = is_wr_q;
    we_d       = we_q;
    re_d       = re_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_v_d    = 1'b0;
    rsp_data_d = rsp_data_q;
    pop        = 1'b0;
    if (err_in) begin
      state_d = S_HALT;
      we_d    = 1'b0;
      re_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            addr_d  = head.addr;
            data_d  = head.data;
            is_wr_d = head.wr;
            we_d    = head.wr;
            re_d    = !head.wr;
            cnt_d   = head.wr ? CNT_W'(WR_HOLD - 1) : '0;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            we_d = 1'b0;
            re_d = 1'b0;
            if (!is_wr_q) begin
              state_d = S_RSP;
              cnt_d   = CNT_W'(RD_LATENCY - 1);
            end else if (GAP_CYCLES == 0) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_GAP;
              cnt_d   = CNT_W'(GAP_CYCLES - 1);
            end
          end
        end
        S_RSP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            rsp_v_d    = 1'b1;
            rsp_data_d = rd_data_in;
            state_d    = S_IDLE;
          end
        end
        S_GAP: begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else             state_d = S_IDLE;
        end
        S_HALT: begin
          we_d = 1'b0;
          re_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_v_q    <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      we_q       <= we_d;
      re_q       <= re_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_v_q    <= rsp_v_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign enable       = !rst && (state_q != S_HALT);
  assign write_enable = we_q;
  assign read_enable  = re_q;
  assign address      = addr_q;
  assign data_in      = data_q;
  assign rsp_valid    = rsp_v_q;
  assign rsp_data     = rsp_data_q;

`ifdef MEM_CMD_ISSUER_STATS_EN
  logic [15:0] wr_cnt_q, rd_cnt_q;

  // Counted at the pop edge, which is the edge entering ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else if (pop) begin
      if (head.wr && (wr_cnt_q != 16'hFFFF))  wr_cnt_q <= wr_cnt_q + 1'b1;
      if (!head.wr && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 1'b1;
    end
  end

  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
`else
  assign wr_count = '0;
  assign rd_count = '0;
`endif

endmodule
